// File: rtl/csr_counter_unit_pkg.sv
// Shared constants and helpers for the machine counter block: owned CSR
// addresses, mcountinhibit bit positions and the CSR address decoder.
package csr_counter_unit_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam int INHIBIT_CY_BIT = 0;
    localparam int INHIBIT_IR_BIT = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH,
        SEL_MCOUNTINHIBIT
    } csr_sel_e;

    // Map a CSR address onto the register it selects in this block.
    function automatic csr_sel_e csr_decode(input logic [11:0] index);
        case (index)
            CSR_MCYCLE:        return SEL_MCYCLE;
            CSR_MCYCLEH:       return SEL_MCYCLEH;
            CSR_MINSTRET:      return SEL_MINSTRET;
            CSR_MINSTRETH:     return SEL_MINSTRETH;
            CSR_MCOUNTINHIBIT: return SEL_MCOUNTINHIBIT;
            default:           return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter_unit_if.sv
// CSR read/write bus shared with the CSR register file. The master drives the
// strobes, indices and write data; the slave answers with read data and hit.
interface csr_counter_unit_if;
    logic        read_enable_csr;
    logic [11:0] csr_read_index;
    logic [31:0] csr_read_data;
    logic        csr_read_hit;
    logic        write_enable_csr;
    logic [11:0] csr_write_index;
    logic [31:0] csr_write_data;

    modport master (
        output read_enable_csr, csr_read_index,
        output write_enable_csr, csr_write_index, csr_write_data,
        input  csr_read_data, csr_read_hit
    );

    modport slave (
        input  read_enable_csr, csr_read_index,
        input  write_enable_csr, csr_write_index, csr_write_data,
        output csr_read_data, csr_read_hit
    );
endinterface

// File: rtl/csr_counter_unit_counter64.sv
// csr_counter64: one machine counter split into 32-bit CSR halves. Handles the
// half writes (which pre-empt the increment), the increment, wrap detection and
// a registered one-cycle overflow pulse. With CSR_COUNTER_SNAPSHOT_EN defined,
// a low-half read captures the matching high half so a following high-half
// read sees a consistent 64-bit value.
module csr_counter64 #(
    parameter int WIDTH = 64  // 33..64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_en,
    input  logic        write_lo,
    input  logic        write_hi,
    input  logic [31:0] write_data,
    input  logic        read_lo,
    input  logic        read_hi,
    output logic [31:0] lo_data,
    output logic [31:0] hi_data,
    output logic        overflow
);

    localparam int HI_W = WIDTH - 32;

    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] value_next;
    logic             wrap;
    logic [63:0]      value_ext;
    logic [31:0]      live_hi;

    // Next counter value: a CSR write replaces one half, otherwise count.
    always_comb begin
        // NOTE: defaults first so every path assigns value_next/wrap and no latch is inferred.
        value_next = value;
        wrap       = 1'b0;
        if (write_lo) begin
            value_next[31:0] = write_data;
        end else if (write_hi) begin
            value_next[WIDTH-1:32] = write_data[HI_W-1:0];
        end else if (count_en) begin
            {wrap, value_next} = {1'b0, value} + (WIDTH + 1)'(1);
        end
    end

    // Counter state and the overflow pulse for the cycle after a wrap.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all clocked state.
        if (reset) begin
            value    <= '0;
            overflow <= 1'b0;
        end else begin
            value    <= value_next;
            overflow <= wrap;
        end
    end

    assign value_ext = 64'(value);
    assign lo_data   = value_ext[31:0];
    assign live_hi   = value_ext[63:32];

`ifdef CSR_COUNTER_SNAPSHOT_EN
    logic [31:0] snap_hi;
    logic        snap_valid;

    // High-half snapshot: set by a low read, consumed by a high read,
    // invalidated by any write to this counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_hi    <= '0;
            snap_valid <= 1'b0;
        end else if (write_lo || write_hi) begin
            snap_valid <= 1'b0;
        end else if (read_lo) begin
            snap_hi    <= live_hi;
            snap_valid <= 1'b1;
        end else if (read_hi) begin
            snap_valid <= 1'b0;
        end
    end

    assign hi_data = snap_valid ? snap_hi : live_hi;
`else
    logic unused_read;
    assign unused_read = read_lo ^ read_hi;
    assign hi_data     = live_hi;
`endif

endmodule

// File: rtl/csr_counter_unit.sv
// csr_counter_unit: mcycle/minstret/mcountinhibit block on the CSR buses.
// Decodes the owned addresses, holds mcountinhibit, instantiates one
// csr_counter64 per counter and muxes the combinational read data.
// Optional feature macro: CSR_COUNTER_SNAPSHOT_EN (high-half read snapshot).
module csr_counter_unit
    import csr_counter_unit_pkg::*;
#(
    parameter int COUNTER_WIDTH = 64  // 33..64
) (
    input  logic                clk,
    input  logic                reset,
    csr_counter_unit_if.slave   csr,
    input  logic                instret_valid,
    output logic                cycle_overflow,
    output logic                instret_overflow
);

    csr_sel_e    rd_sel;
    csr_sel_e    wr_sel;
    logic        inhibit_cy;
    logic        inhibit_ir;
    logic [31:0] mcycle_lo;
    logic [31:0] mcycle_hi;
    logic [31:0] minstret_lo;
    logic [31:0] minstret_hi;
    logic [31:0] read_data;
    logic        read_hit;

    assign rd_sel = csr.read_enable_csr  ? csr_decode(csr.csr_read_index)  : SEL_NONE;
    assign wr_sel = csr.write_enable_csr ? csr_decode(csr.csr_write_index) : SEL_NONE;

    // mcountinhibit: only CY and IR are implemented; a write applies next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inhibit_cy <= 1'b0;
            inhibit_ir <= 1'b0;
        end else if (wr_sel == SEL_MCOUNTINHIBIT) begin
            inhibit_cy <= csr.csr_write_data[INHIBIT_CY_BIT];
            inhibit_ir <= csr.csr_write_data[INHIBIT_IR_BIT];
        end
    end

    csr_counter64 #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clk        (clk),
        .reset      (reset),
        .count_en   (!inhibit_cy),
        .write_lo   (wr_sel == SEL_MCYCLE),
        .write_hi   (wr_sel == SEL_MCYCLEH),
        .write_data (csr.csr_write_data),
        .read_lo    (rd_sel == SEL_MCYCLE),
        .read_hi    (rd_sel == SEL_MCYCLEH),
        .lo_data    (mcycle_lo),
        .hi_data    (mcycle_hi),
        .overflow   (cycle_overflow)
    );

    csr_counter64 #(.WIDTH(COUNTER_WIDTH)) u_minstret (
        .clk        (clk),
        .reset      (reset),
        .count_en   (instret_valid && !inhibit_ir),
        .write_lo   (wr_sel == SEL_MINSTRET),
        .write_hi   (wr_sel == SEL_MINSTRETH),
        .write_data (csr.csr_write_data),
        .read_lo    (rd_sel == SEL_MINSTRET),
        .read_hi    (rd_sel == SEL_MINSTRETH),
        .lo_data    (minstret_lo),
        .hi_data    (minstret_hi),
        .overflow   (instret_overflow)
    );

    // Read mux from current state; silent on a miss and while in reset.
    always_comb begin
        read_data = '0;
        read_hit  = 1'b1;
        unique case (rd_sel)
            SEL_MCYCLE:        read_data = mcycle_lo;
            SEL_MCYCLEH:       read_data = mcycle_hi;
            SEL_MINSTRET:      read_data = minstret_lo;
            SEL_MINSTRETH:     read_data = minstret_hi;
            SEL_MCOUNTINHIBIT: read_data = {29'b0, inhibit_ir, 1'b0, inhibit_cy};
            SEL_NONE:          read_hit  = 1'b0;
        endcase
        if (reset) begin
            read_data = '0;
            read_hit  = 1'b0;
        end
    end

    assign csr.csr_read_data = read_data;
    assign csr.csr_read_hit  = read_hit;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Self-checking bench for csr_counter_unit: directed sequences, a table of
// read vectors and randomized traffic checked against a 64-bit arithmetic
// model of the counters. Honours CSR_COUNTER_SNAPSHOT_EN for expectations.
module tb_csr_counter_unit;

    logic clk = 1'b0;
    logic reset;
    logic instret_valid;
    logic cycle_overflow;
    logic instret_overflow;

    csr_counter_unit_if bus ();

    csr_counter_unit #(.COUNTER_WIDTH(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .csr              (bus.slave),
        .instret_valid    (instret_valid),
        .cycle_overflow   (cycle_overflow),
        .instret_overflow (instret_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] m_cyc, m_ins;
    bit          m_cy, m_ir;
    bit          m_ovf_c, m_ovf_i;
    logic [31:0] m_snap_c, m_snap_i;
    bit          m_sv_c, m_sv_i;

    logic [31:0] last_data;
    bit          last_hit;
    int          cyc_pulses, ins_pulses;

    typedef struct {
        bit          re;
        logic [11:0] idx;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = '0; m_ins = '0; m_cy = 0; m_ir = 0;
        m_ovf_c = 0; m_ovf_i = 0;
        m_snap_c = '0; m_snap_i = '0; m_sv_c = 0; m_sv_i = 0;
    endtask

    function automatic logic [32:0] model_read(input bit re, input logic [11:0] idx);
        if (!re) return '0;
        case (idx)
            12'hB00: return {1'b1, m_cyc[31:0]};
            12'hB02: return {1'b1, m_ins[31:0]};
`ifdef CSR_COUNTER_SNAPSHOT_EN
            12'hB80: return {1'b1, m_sv_c ? m_snap_c : m_cyc[63:32]};
            12'hB82: return {1'b1, m_sv_i ? m_snap_i : m_ins[63:32]};
`else
            12'hB80: return {1'b1, m_cyc[63:32]};
            12'hB82: return {1'b1, m_ins[63:32]};
`endif
            12'h320: return {1'b1, 29'b0, m_ir, 1'b0, m_cy};
            default: return '0;
        endcase
    endfunction

    // Advance the model across one rising edge using the pre-edge state.
    task automatic model_edge(input bit re, input logic [11:0] ridx, input bit we,
                              input logic [11:0] widx, input logic [31:0] wd, input bit iv);
        logic [63:0] nc, ni;
        bit oc, oi;
        nc = m_cyc; ni = m_ins; oc = 0; oi = 0;
        if (we && widx == 12'hB00)      nc = {m_cyc[63:32], wd};
        else if (we && widx == 12'hB80) nc = {wd, m_cyc[31:0]};
        else if (!m_cy) begin nc = m_cyc + 64'd1; oc = (m_cyc == '1); end
        if (we && widx == 12'hB02)      ni = {m_ins[63:32], wd};
        else if (we && widx == 12'hB82) ni = {wd, m_ins[31:0]};
        else if (iv && !m_ir) begin ni = m_ins + 64'd1; oi = (m_ins == '1); end
        if (we && (widx == 12'hB00 || widx == 12'hB80))      m_sv_c = 0;
        else if (re && ridx == 12'hB00) begin m_snap_c = m_cyc[63:32]; m_sv_c = 1; end
        else if (re && ridx == 12'hB80)                      m_sv_c = 0;
        if (we && (widx == 12'hB02 || widx == 12'hB82))      m_sv_i = 0;
        else if (re && ridx == 12'hB02) begin m_snap_i = m_ins[63:32]; m_sv_i = 1; end
        else if (re && ridx == 12'hB82)                      m_sv_i = 0;
        if (we && widx == 12'h320) begin m_cy = wd[0]; m_ir = wd[2]; end
        m_cyc = nc; m_ins = ni; m_ovf_c = oc; m_ovf_i = oi;
    endtask

    // One clock cycle: drive, compare against the model, then take the edge.
    task automatic step(input bit re, input logic [11:0] ridx, input bit we,
                        input logic [11:0] widx, input logic [31:0] wd, input bit iv,
                        input string tag);
        logic [32:0] exp;
        bus.read_enable_csr  = re;
        bus.csr_read_index   = ridx;
        bus.write_enable_csr = we;
        bus.csr_write_index  = widx;
        bus.csr_write_data   = wd;
        instret_valid        = iv;
        #1;
        exp = model_read(re, ridx);
        last_data = bus.csr_read_data;
        last_hit  = bus.csr_read_hit;
        if (cycle_overflow)   cyc_pulses++;
        if (instret_overflow) ins_pulses++;
        check({tag, " hit"},  64'(bus.csr_read_hit),  64'(exp[32]));
        check({tag, " data"}, 64'(bus.csr_read_data), 64'(exp[31:0]));
        check({tag, " cyc_ovf"}, 64'(cycle_overflow),   64'(m_ovf_c));
        check({tag, " ins_ovf"}, 64'(instret_overflow), 64'(m_ovf_i));
        model_edge(re, ridx, we, widx, wd, iv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit iv);
        for (int i = 0; i < n; i++) step(0, 12'h000, 0, 12'h000, 32'h0, iv, "idle");
    endtask

    task automatic wr(input logic [11:0] widx, input logic [31:0] wd, input bit iv);
        step(0, 12'h000, 1, widx, wd, iv, "write");
    endtask

    task automatic rd(input logic [11:0] ridx, input bit iv, input string tag);
        step(1, ridx, 0, 12'h000, 32'h0, iv, tag);
    endtask

    logic [11:0] pool[8];
    logic [32:0] exp_rst;

    initial begin
        vecs[0] = '{1'b1, 12'hB00, 1'b1, 32'd13};
        vecs[1] = '{1'b1, 12'hB80, 1'b1, 32'd0};
        vecs[2] = '{1'b1, 12'hB02, 1'b1, 32'd0};
        vecs[3] = '{1'b1, 12'hB82, 1'b1, 32'd0};
        vecs[4] = '{1'b1, 12'h320, 1'b1, 32'h5};
        vecs[5] = '{1'b1, 12'h300, 1'b0, 32'd0};
        vecs[6] = '{1'b0, 12'hB00, 1'b0, 32'd0};
        vecs[7] = '{1'b1, 12'hB01, 1'b0, 32'd0};
        vecs[8] = '{1'b1, 12'hF14, 1'b0, 32'd0};
        pool = '{12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h320, 12'h300, 12'hB01, 12'hC00};

        // Reset state, with a live read strobe aimed at an owned address
        reset = 1'b1;
        bus.read_enable_csr = 1'b1; bus.csr_read_index = 12'hB00;
        bus.write_enable_csr = 1'b0; bus.csr_write_index = '0; bus.csr_write_data = '0;
        instret_valid = 1'b0;
        model_reset();
        cyc_pulses = 0; ins_pulses = 0;
        @(posedge clk); @(posedge clk); #1;
        check("reset hit", 64'(bus.csr_read_hit), 64'd0);
        check("reset data", 64'(bus.csr_read_data), 64'd0);
        check("reset cyc_ovf", 64'(cycle_overflow), 64'd0);
        check("reset ins_ovf", 64'(instret_overflow), 64'd0);
        reset = 1'b0;

        // Free-running mcycle after reset
        idle(10, 0);
        rd(12'hB00, 0, "mcycle after 10");
        check("mcycle after 10 const", 64'(last_data), 64'd10);
        rd(12'h320, 0, "inhibit reset");
        check("inhibit reset const", 64'(last_data), 64'd0);

        // Inhibit both counters; the write cycle still counts mcycle
        wr(12'h320, 32'h5, 0);
        idle(4, 1);
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].re, vecs[i].idx, 0, 12'h000, 32'h0, 0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d const hit", i),  64'(last_hit),  64'(vecs[i].hit));
            check($sformatf("vec%0d const data", i), 64'(last_data), 64'(vecs[i].data));
        end

        // Clear inhibit: write cycle uses the old inhibit value
        wr(12'h320, 32'h0, 1);
        rd(12'hB00, 1, "mcycle resume");
        check("mcycle resume const", 64'(last_data), 64'd13);
        rd(12'hB02, 0, "minstret resume");
        check("minstret resume const", 64'(last_data), 64'd1);

        // mcycle wrap
        wr(12'hB80, 32'hFFFF_FFFF, 0);
        wr(12'hB00, 32'hFFFF_FFFE, 0);
        cyc_pulses = 0;
        idle(4, 0);
        check("cycle_overflow pulse count", 64'(cyc_pulses), 64'd1);
        rd(12'hB80, 0, "mcycleh after wrap");
        check("mcycleh after wrap const", 64'(last_data), 64'd0);

        // minstret wrap
        wr(12'hB82, 32'hFFFF_FFFF, 0);
        wr(12'hB02, 32'hFFFF_FFFF, 0);
        ins_pulses = 0;
        idle(1, 1);
        idle(3, 0);
        check("instret_overflow pulse count", 64'(ins_pulses), 64'd1);

        // Write beats a same-cycle retire
        wr(12'hB02, 32'h1234, 1);
        rd(12'hB02, 0, "minstret write");
        check("minstret write const", 64'(last_data), 64'h1234);

        // High-half snapshot across a low-half carry
        wr(12'hB80, 32'h0, 0);
        wr(12'hB00, 32'hFFFF_FFFF, 0);
        rd(12'hB00, 0, "snap lo");
        check("snap lo const", 64'(last_data), 64'hFFFF_FFFF);
        idle(1, 0);
        rd(12'hB80, 0, "snap hi");
`ifdef CSR_COUNTER_SNAPSHOT_EN
        check("snap hi const", 64'(last_data), 64'd0);
`else
        check("snap hi const", 64'(last_data), 64'd1);
`endif
        rd(12'hB80, 0, "live hi");
        check("live hi const", 64'(last_data), 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit          we;
            logic [11:0] widx;
            logic [31:0] wd;
            we   = ($urandom_range(0, 7) == 0);
            widx = pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFF_FFFF;
                1:       wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: wd = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], we, widx, wd,
                 1'($urandom_range(0, 1)), "rand");
        end

        // Reset in the middle of a cycle while counting
        wr(12'h320, 32'h0, 1);
        idle(3, 1);
        bus.read_enable_csr = 1'b1; bus.csr_read_index = 12'hB00; instret_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        exp_rst = model_read(1'b1, 12'hB00);
        check("midreset hit", 64'(bus.csr_read_hit), 64'd0);
        check("midreset data", 64'(bus.csr_read_data), 64'd0);
        check("midreset model data", 64'(bus.csr_read_data), 64'(exp_rst[31:0]));
        check("midreset cyc_ovf", 64'(cycle_overflow), 64'd0);
        check("midreset ins_ovf", 64'(instret_overflow), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd(12'hB00, 0, "post reset 0");
        check("post reset 0 const", 64'(last_data), 64'd0);
        rd(12'hB00, 0, "post reset 1");
        check("post reset 1 const", 64'(last_data), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
